// File: rtl/encrypt_pkg.sv
// Shared constants and types for the column-block encryption sequencer.
// Parameter-set derivations, ciphertext sizing and the controller state enum.
package encrypt_pkg;

  function automatic int m_of(input int ps);
    return (ps == 1) ? 12 : 13;
  endfunction

  function automatic int t_of(input int ps);
    case (ps)
      1:       return 64;
      2:       return 96;
      4:       return 119;
      default: return 128;
    endcase
  endfunction

  function automatic int n_of(input int ps);
    case (ps)
      1:       return 3488;
      2:       return 4608;
      3:       return 6688;
      4:       return 6960;
      default: return 8192;
    endcase
  endfunction

  function automatic int l_of(input int ps);
    return m_of(ps) * t_of(ps);
  endfunction

  function automatic int ct_words_of(input int ps);
    return (l_of(ps) + 31) / 32;
  endfunction

  function automatic int ct_aw_of(input int ps);
    return $clog2(ct_words_of(ps));
  endfunction

  localparam int ENC_PSET_DEFAULT = 1;
  localparam int ENC_L_DEFAULT    = l_of(ENC_PSET_DEFAULT);
  localparam int ENC_CTW_DEFAULT  = ct_words_of(ENC_PSET_DEFAULT);
  localparam int ENC_AW_DEFAULT   = ct_aw_of(ENC_PSET_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DEPS,
    ST_KICK,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } enc_ctrl_state_t;

endpackage

// File: rtl/ct_skid_fifo.sv
// Two-entry synchronous FIFO that decouples the RAM read latency from the
// ciphertext sink's backpressure. Push while full is accepted only with a pop.
module ct_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem_q;
  logic              wp_q, rp_q;
  logic [1:0]        cnt_q;
  logic              do_push, do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign count   = cnt_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din;
        wp_q        <= ~wp_q;
      end
      if (do_pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/encrypt_seq_ctrl.sv
// Sequencer: waits for error vector and public key, launches the encryptor,
// then streams the ciphertext RAM out as a valid/ready word stream.
module encrypt_seq_ctrl
  import encrypt_pkg::*;
#(
  parameter int  parameter_set = 1,
  localparam int L        = l_of(parameter_set),
  localparam int CT_WORDS = (L + 31) / 32,
  localparam int AW       = $clog2(CT_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          e_ready,
  input  logic          pk_ready,
  output logic          enc_start,
  input  logic          enc_done,
  output logic          rd_en_c,
  output logic [AW-1:0] addr_rd_c,
  input  logic [31:0]   cipher,
  output logic [31:0]   ct_data,
  output logic          ct_valid,
  input  logic          ct_ready,
  output logic          ct_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0]   PTR_END = (AW+1)'(CT_WORDS);
  localparam logic [AW-1:0] W_LAST  = AW'(CT_WORDS - 1);

  enc_ctrl_state_t state_q, state_d;
  logic [AW:0]     ptr_q, ptr_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic            inflight_q;

  logic            in_drain, accept, issue;
  logic            fifo_full, fifo_empty;
  logic [1:0]      fifo_cnt;
  logic [2:0]      occ;

  assign in_drain = (state_q == ST_DRAIN);
  assign ct_valid = !fifo_empty;
  assign accept   = ct_valid && ct_ready;
  assign ct_last  = ct_valid && (wcnt_q == W_LAST);

  // Occupancy after this cycle's pop; keeps the pipe full at one word/cycle
  // while guaranteeing the returning read always has a FIFO slot.
  assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, accept};
  assign issue = in_drain && (ptr_q != PTR_END) && (occ < 3'd2)
                 && (!fifo_full || accept);

  assign enc_start = (state_q == ST_KICK);
  assign rd_en_c   = in_drain;
  assign addr_rd_c = in_drain ? ptr_q[AW-1:0] : '0;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done      = (state_q == ST_FINISH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_WAIT_DEPS;
      ST_WAIT_DEPS: if (e_ready && pk_ready) state_d = ST_KICK;
      ST_KICK:      state_d = ST_RUN;
      ST_RUN:       if (enc_done) state_d = ST_DRAIN;
      ST_DRAIN:     if (accept && ct_last) state_d = ST_FINISH;
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = issue  ? ptr_q + 1'b1  : ptr_q;
    wcnt_d = accept ? wcnt_q + 1'b1 : wcnt_q;
    if (!in_drain) begin
      ptr_d  = '0;
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      wcnt_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wcnt_q     <= wcnt_d;
      inflight_q <= issue;
    end
  end

  ct_skid_fifo #(.W(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (cipher),
    .pop   (accept),
    .dout  (ct_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule
